external_memory_responder: RTL and testbench

Target-side model of the CPU external bus: it answers the memory controller's `ExternalDrive` command codes (instruction fetch, memory read, memory write) from an internal word-addressed RAM. It inserts a programmable number of wait states and then raises `ExternalExchangeReady`. During fetch/read responses it drives the shared data bus and otherwise leaves it high-impedance. It sits outside the CPU core in the top-level system and in every CPU testbench.

---
 rtl/ext_bus_pkg.sv | 27 ++
 rtl/responder_ram.sv | 41 ++++
 rtl/external_memory_responder.sv | 133 +++++++++++++
 tb/tb_external_memory_responder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ext_bus_pkg.sv
// Shared definitions for the CPU external bus: command codes, payload widths and responder state encoding.
package ext_bus_pkg;

    localparam int unsigned EXT_CMD_W  = 3;
    localparam int unsigned EXT_ADDR_W = 32;
    localparam int unsigned EXT_DATA_W = 32;

    localparam logic [EXT_CMD_W-1:0] EXT_NOP   = 3'b000;
    localparam logic [EXT_CMD_W-1:0] EXT_FETCH = 3'b001;
    localparam logic [EXT_CMD_W-1:0] EXT_MRD   = 3'b010;
    localparam logic [EXT_CMD_W-1:0] EXT_MWR   = 3'b011;
    localparam logic [EXT_CMD_W-1:0] EXT_IORD  = 3'b100;
    localparam logic [EXT_CMD_W-1:0] EXT_IOWR  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESPOND,
        ST_HOLD
    } state_t;

    // Commands whose response places data on the shared bus.
    function automatic logic is_read_cmd(input logic [EXT_CMD_W-1:0] cmd);
        return (cmd == EXT_FETCH) || (cmd == EXT_MRD);
    endfunction

endpackage

// File: rtl/responder_ram.sv
// Word-addressed RAM with a registered read-on-enable port and a preload write port that wins index collisions.
module responder_ram
    import ext_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [EXT_DATA_W-1:0] wdata,
    output logic [EXT_DATA_W-1:0] rdata,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [EXT_DATA_W-1:0] load_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [EXT_DATA_W-1:0] mem [DEPTH];

    // Preload is written last so it overrides a same-edge bus write to the same word.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/external_memory_responder.sv
// Target-side external bus model: waits, then answers fetch/read/write commands from an internal RAM.
module external_memory_responder
    import ext_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [EXT_CMD_W-1:0]  ext_drive,
    input  logic [EXT_ADDR_W-1:0] ext_addr,
    inout  wire  [EXT_DATA_W-1:0] ext_data,
    output logic                  ext_ready,
    output logic                  busy,
    output logic                  access_error,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [EXT_DATA_W-1:0] load_data
);

    localparam int unsigned CNT_W = 8;

    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 255) begin : g_bad_wait
            $error("WAIT_CYCLES must be within 1..255");
        end
    endgenerate

    state_t                 state, state_d;
    logic [EXT_CMD_W-1:0]   cmd_q, cmd_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   drive_q, drive_d;
    logic                   ready_d, busy_d, aerr_d;
    logic                   ram_en, ram_we;
    logic                   addr_bad;
    logic [EXT_DATA_W-1:0]  ram_rdata;

    assign addr_bad = |ext_addr[EXT_ADDR_W-1:ADDR_WIDTH];

    // cnt holds the wait edges still owed; the access happens on the edge that finds it at zero.
    always_comb begin
        state_d = state;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ram_en  = 1'b0;
        ram_we  = 1'b0;
        aerr_d  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ext_drive != EXT_NOP) begin
                    cmd_d   = ext_drive;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ext_drive == EXT_NOP) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (ext_drive != cmd_q) begin
                    cmd_d = ext_drive;
                    cnt_d = CNT_W'(WAIT_CYCLES);
                end else if (cnt_q == '0) begin
                    err_d   = addr_bad || cmd_q[2];
                    aerr_d  = err_d;
                    ram_en  = !err_d && rst;
                    ram_we  = (cmd_q == EXT_MWR);
                    state_d = ST_RESPOND;
                end else begin
                    cnt_d = CNT_W'(cnt_q - 1'b1);
                end
            end
            ST_RESPOND, ST_HOLD: begin
                if (ext_drive == EXT_NOP) begin
                    state_d = ST_IDLE;
                end else if (ext_drive != cmd_q) begin
                    cmd_d   = ext_drive;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_RESPOND) || (state_d == ST_HOLD);
        busy_d  = (state_d != ST_IDLE);
        drive_d = ready_d && is_read_cmd(cmd_d);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            cmd_q        <= EXT_NOP;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            drive_q      <= 1'b0;
            ext_ready    <= 1'b0;
            busy         <= 1'b0;
            access_error <= 1'b0;
        end else begin
            state        <= state_d;
            cmd_q        <= cmd_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            drive_q      <= drive_d;
            ext_ready    <= ready_d;
            busy         <= busy_d;
            access_error <= aerr_d;
        end
    end

    responder_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .en        (ram_en),
        .we        (ram_we),
        .addr      (ext_addr[ADDR_WIDTH-1:0]),
        .wdata     (ext_data),
        .rdata     (ram_rdata),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    // Errored reads answer with zero rather than whatever the RAM register last held.
    assign ext_data = drive_q ? (err_q ? '0 : ram_rdata) : 'z;

endmodule

// File: tb/tb_external_memory_responder.sv
// Directed bench for external_memory_responder (ADDR_WIDTH=10, WAIT_CYCLES=2).
module tb_external_memory_responder;
    import ext_bus_pkg::*;

    localparam int unsigned AW = 10;
    localparam logic [31:0] PAT = 32'hA5A5_5A5A;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    ext_drive;
    logic [31:0]   ext_addr;
    wire  [31:0]   ext_data;
    logic          ext_ready;
    logic          busy;
    logic          access_error;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic          tb_oe;
    logic [31:0]   tb_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ext_data = tb_oe ? tb_data : 'z;

    external_memory_responder #(
        .ADDR_WIDTH(AW),
        .WAIT_CYCLES(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ext_drive    (ext_drive),
        .ext_addr     (ext_addr),
        .ext_data     (ext_data),
        .ext_ready    (ext_ready),
        .busy         (busy),
        .access_error (access_error),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; ext_drive = EXT_NOP; ext_addr = '0; load_en = 1'b0;
        load_addr = '0; load_data = '0; tb_oe = 1'b1; tb_data = PAT;
        tick(); tick();
        checks++; if (ext_ready !== 1'b0) begin errors++; $display("FAIL reset_ready actual=%b required=0", ext_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy actual=%b required=0", busy); end
        checks++; if (access_error !== 1'b0) begin errors++; $display("FAIL reset_error actual=%b required=0", access_error); end
        checks++; if (ext_data !== PAT) begin errors++; $display("FAIL reset_bus_released actual=%h required=%h", ext_data, PAT); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        preload(AW'(5), 32'hDEADBEEF);
        tb_oe = 1'b0; ext_drive = EXT_FETCH; ext_addr = '0;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fetch_busy actual=%b required=1", busy); end
        ext_addr = 32'd5;
        tick(); tick();
        checks++; if (ext_ready !== 1'b0) begin errors++; $display("FAIL fetch_ready_early actual=%b required=0", ext_ready); end
        tick();
        checks++; if (ext_ready !== 1'b1) begin errors++; $display("FAIL fetch_ready actual=%b required=1", ext_ready); end
        checks++; if (ext_data !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_data actual=%h required=deadbeef", ext_data); end
        tick();
        checks++; if (ext_ready !== 1'b1 || ext_data !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_hold actual=%b/%h required=1/deadbeef", ext_ready, ext_data); end
        tb_oe = 1'b1; tb_data = PAT; ext_drive = EXT_NOP;
        tick();
        checks++; if (ext_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fetch_release ready/busy actual=%b/%b required=0/0", ext_ready, busy); end
        checks++; if (ext_data !== PAT) begin errors++; $display("FAIL fetch_bus_released actual=%h required=%h", ext_data, PAT); end
    endtask

    task automatic test_write_read();
        tb_oe = 1'b1; tb_data = 32'h12345678; ext_addr = 32'd9; ext_drive = EXT_MWR;
        tick(); tick(); tick(); tick();
        checks++; if (ext_ready !== 1'b1) begin errors++; $display("FAIL write_ready actual=%b required=1", ext_ready); end
        tb_data = 32'hCAFEF00D;
        repeat (7) tick();
        checks++; if (dut.u_ram.mem[9] !== 32'h12345678) begin errors++; $display("FAIL write_single_commit actual=%h required=12345678", dut.u_ram.mem[9]); end
        // Read follows the held write directly.
        tb_oe = 1'b0; ext_drive = EXT_MRD;
        tick();
        checks++; if (ext_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_read_switch ready/busy actual=%b/%b required=0/1", ext_ready, busy); end
        tick(); tick(); tick();
        checks++; if (ext_ready !== 1'b1 || ext_data !== 32'h12345678) begin errors++; $display("FAIL read_data actual=%b/%h required=1/12345678", ext_ready, ext_data); end
        // Fetch follows the read directly.
        ext_drive = EXT_FETCH; ext_addr = 32'd5;
        tick();
        checks++; if (ext_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_fetch_switch ready/busy actual=%b/%b required=0/1", ext_ready, busy); end
        tick(); tick(); tick();
        checks++; if (ext_ready !== 1'b1 || ext_data !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_fetch_data actual=%b/%h required=1/deadbeef", ext_ready, ext_data); end
        tb_oe = 1'b1; tb_data = PAT; ext_drive = EXT_NOP;
        tick();
    endtask

    task automatic test_abort();
        logic seen_ready;
        seen_ready = 1'b0;
        tb_oe = 1'b1; tb_data = PAT; ext_addr = 32'd9; ext_drive = EXT_MRD;
        tick();
        ext_drive = EXT_NOP;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy actual=%b required=0", busy); end
        for (int i = 0; i < 4; i++) begin
            if (ext_ready !== 1'b0) seen_ready = 1'b1;
            tick();
        end
        checks++; if (seen_ready !== 1'b0) begin errors++; $display("FAIL abort_no_ready actual=%b required=0", seen_ready); end
        // Aborted write must not reach the RAM.
        tb_data = 32'hFFFF0000; ext_drive = EXT_MWR;
        tick(); tick();
        ext_drive = EXT_NOP;
        tick(); tick(); tick();
        checks++; if (dut.u_ram.mem[9] !== 32'h12345678) begin errors++; $display("FAIL abort_ram_unchanged actual=%h required=12345678", dut.u_ram.mem[9]); end
    endtask

    task automatic test_out_of_range();
        preload(AW'(0), 32'h11111111);
        tb_oe = 1'b0; ext_addr = 32'h0000_0400; ext_drive = EXT_MRD;
        tick(); tick(); tick();
        checks++; if (access_error !== 1'b0) begin errors++; $display("FAIL oor_error_early actual=%b required=0", access_error); end
        tick();
        checks++; if (ext_ready !== 1'b1 || access_error !== 1'b1) begin errors++; $display("FAIL oor_read_ready_error actual=%b/%b required=1/1", ext_ready, access_error); end
        checks++; if (ext_data !== 32'h0) begin errors++; $display("FAIL oor_read_data actual=%h required=00000000", ext_data); end
        tick();
        checks++; if (access_error !== 1'b0 || ext_ready !== 1'b1) begin errors++; $display("FAIL oor_error_pulse error/ready actual=%b/%b required=0/1", access_error, ext_ready); end
        ext_drive = EXT_NOP; tb_oe = 1'b1; tb_data = 32'hBADBAD00;
        tick();
        ext_drive = EXT_MWR;
        tick(); tick(); tick(); tick();
        checks++; if (ext_ready !== 1'b1 || access_error !== 1'b1) begin errors++; $display("FAIL oor_write_ready_error actual=%b/%b required=1/1", ext_ready, access_error); end
        ext_drive = EXT_NOP;
        tick();
        checks++; if (dut.u_ram.mem[0] !== 32'h11111111) begin errors++; $display("FAIL oor_write_discarded actual=%h required=11111111", dut.u_ram.mem[0]); end
        ext_addr = 32'd3; ext_drive = EXT_IORD;
        tick(); tick(); tick(); tick();
        checks++; if (ext_ready !== 1'b1 || access_error !== 1'b1) begin errors++; $display("FAIL io_ready_error actual=%b/%b required=1/1", ext_ready, access_error); end
        ext_drive = EXT_NOP;
        tick();
    endtask

    task automatic test_reset_mid_write();
        preload(AW'(12), 32'hAAAA0000);
        tb_oe = 1'b1; tb_data = 32'h55555555; ext_addr = 32'd12; ext_drive = EXT_MWR;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (ext_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstw_ready_busy actual=%b/%b required=0/0", ext_ready, busy); end
        checks++; if (dut.u_ram.mem[12] !== 32'hAAAA0000) begin errors++; $display("FAIL rstw_ram_unchanged actual=%h required=aaaa0000", dut.u_ram.mem[12]); end
        checks++; if (ext_data !== 32'h55555555) begin errors++; $display("FAIL rstw_bus_released actual=%h required=55555555", ext_data); end
        ext_drive = EXT_NOP; rst = 1'b1;
        tick();
        tb_oe = 1'b0; ext_drive = EXT_FETCH; ext_addr = '0;
        tick();
        ext_addr = 32'd12;
        tick(); tick(); tick();
        checks++; if (ext_ready !== 1'b1 || ext_data !== 32'hAAAA0000) begin errors++; $display("FAIL rstw_fetch_after actual=%b/%h required=1/aaaa0000", ext_ready, ext_data); end
        tb_oe = 1'b1; tb_data = PAT; ext_drive = EXT_NOP;
        tick();
    endtask

    task automatic test_preload_collision();
        tb_oe = 1'b1; tb_data = 32'h77777777; ext_addr = 32'd7; ext_drive = EXT_MWR;
        tick(); tick(); tick();
        load_en = 1'b1; load_addr = AW'(7); load_data = 32'h0BADF00D;
        tick();
        load_en = 1'b0;
        checks++; if (ext_ready !== 1'b1) begin errors++; $display("FAIL collision_ready actual=%b required=1", ext_ready); end
        checks++; if (dut.u_ram.mem[7] !== 32'h0BADF00D) begin errors++; $display("FAIL collision_preload_wins actual=%h required=0badf00d", dut.u_ram.mem[7]); end
        ext_drive = EXT_NOP;
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_write_read();
        test_abort();
        test_out_of_range();
        test_reset_mid_write();
        test_preload_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
